// File: rtl/apple_gen_if.sv
// Apple generator bundle: refresh/restart requests and pixel
// position in, apple position, pixel flag, busy and score out.
interface apple_gen_if;
   logic        apple_refresh;
   logic [1:0]  game_status;
   logic [11:0] x_pos;
   logic [11:0] y_pos;
   logic [11:0] apple_x;
   logic [11:0] apple_y;
   logic        apple;
   logic        busy;
   logic [7:0]  apple_count;

   modport master (
      output apple_refresh,
      output game_status,
      output x_pos,
      output y_pos,
      input  apple_x,
      input  apple_y,
      input  apple,
      input  busy,
      input  apple_count
   );

   modport slave (
      input  apple_refresh,
      input  game_status,
      input  x_pos,
      input  y_pos,
      output apple_x,
      output apple_y,
      output apple,
      output busy,
      output apple_count
   );
endinterface

// File: rtl/apple_gen.sv
// Apple placement responder: LFSR-drawn apple positions kept
// clear of the wall, pixel flag for the colour mux, eaten count.
module apple_gen #(
   parameter int          H_RES     = 1280,
   parameter int          V_RES     = 720,
   parameter int          WALL      = 30,
   parameter int          MARGIN    = 20,
   parameter int          SIZE      = 10,
   parameter int          INIT_X    = 400,
   parameter int          INIT_Y    = 200,
   parameter int          MAX_TRIES = 64,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input logic        clk,
   input logic        rst_n,
   apple_gen_if.slave ag
);

   localparam logic [11:0] XMIN = 12'(WALL + MARGIN);
   localparam logic [11:0] YMIN = 12'(WALL + MARGIN);
   localparam logic [11:0] XMAX = 12'(H_RES - WALL - MARGIN);
   localparam logic [11:0] YMAX = 12'(V_RES - WALL - MARGIN);
   localparam logic [11:0] IX   = 12'(INIT_X);
   localparam logic [11:0] IY   = 12'(INIT_Y);
   localparam logic [11:0] SZ   = 12'(SIZE);
   localparam logic [7:0]  LAST = 8'(MAX_TRIES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAW,
      CHECK,
      COMMIT
   } state_t;

   state_t      state_q;
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;
   logic [7:0]  tries_q;
   logic        refresh_q;
   logic [11:0] cand_x_q;
   logic [11:0] cand_y_q;
   logic [11:0] apple_x_q;
   logic [11:0] apple_y_q;
   logic        busy_q;
   logic [7:0]  count_q;

   logic req;
   logic restart;
   logic ok;
   logic at_min;
   logic [7:0] count_d;

   assign lfsr_d = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   assign req     = ag.apple_refresh & ~refresh_q;
   assign restart = (ag.game_status == 2'b10);

   assign ok = (cand_x_q >= XMIN) && (cand_x_q <= XMAX) &&
               (cand_y_q >= YMIN) && (cand_y_q <= YMAX) &&
               !((cand_x_q == apple_x_q) && (cand_y_q == apple_y_q));

   assign at_min  = (apple_x_q == XMIN) && (apple_y_q == YMIN);
   assign count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lfsr_q    <= SEED;
         tries_q   <= '0;
         refresh_q <= 1'b0;
         cand_x_q  <= '0;
         cand_y_q  <= '0;
         apple_x_q <= IX;
         apple_y_q <= IY;
         busy_q    <= 1'b0;
         count_q   <= '0;
      end else begin
         lfsr_q    <= lfsr_d;
         refresh_q <= ag.apple_refresh;
         if (restart) begin
            state_q   <= IDLE;
            tries_q   <= '0;
            apple_x_q <= IX;
            apple_y_q <= IY;
            busy_q    <= 1'b0;
            count_q   <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (req) begin
                     state_q <= DRAW;
                     busy_q  <= 1'b1;
                     tries_q <= '0;
                  end
               end
               DRAW: begin
                  cand_x_q <= {1'b0, lfsr_q[10:0]};
                  cand_y_q <= {2'b0, lfsr_q[15:11], lfsr_q[4:0]};
                  state_q  <= CHECK;
               end
               CHECK: begin
                  if (ok) begin
                     state_q <= COMMIT;
                  end else if (tries_q != LAST) begin
                     state_q <= DRAW;
                     tries_q <= tries_q + 8'd1;
                  end else begin
                     // give up: park in a corner not already holding the apple
                     state_q  <= COMMIT;
                     cand_x_q <= at_min ? XMAX : XMIN;
                     cand_y_q <= at_min ? YMAX : YMIN;
                  end
               end
               COMMIT: begin
                  apple_x_q <= cand_x_q;
                  apple_y_q <= cand_y_q;
                  count_q   <= count_d;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ag.apple = (ag.x_pos >= apple_x_q - SZ) &&
                     (ag.x_pos <= apple_x_q + SZ) &&
                     (ag.y_pos >= apple_y_q - SZ) &&
                     (ag.y_pos <= apple_y_q + SZ);

   assign ag.apple_x     = apple_x_q;
   assign ag.apple_y     = apple_y_q;
   assign ag.busy        = busy_q;
   assign ag.apple_count = count_q;

endmodule

// File: tb/tb_apple_gen.sv
// Bench for apple_gen: LFSR reference model feeding a scoreboard,
// plus a one-try instance for the fallback corners.
module tb_apple_gen;

   logic clk;
   logic rst_n;

   apple_gen_if if0 ();
   apple_gen_if if1 ();

   apple_gen dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .ag    (if0.slave)
   );

   apple_gen #(
      .MAX_TRIES (1),
      .SEED      (16'hFFFF)
   ) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .ag    (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic [7:0]  c;
      int          n;
   } exp_t;

   exp_t sbq[$];

   int total  = 0;
   int passed = 0;

   logic [15:0] m0;
   logic [15:0] m1;
   logic [11:0] ax0, ay0;
   logic [7:0]  c0;
   logic [11:0] ax1, ay1;
   logic [7:0]  c1;

   function automatic logic [15:0] nx(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic bit in_field(input logic [11:0] x,
                                   input logic [11:0] y);
      return x >= 50 && x <= 1230 && y >= 50 && y <= 670;
   endfunction

   // l is the LFSR value seen by the first DRAW
   function automatic exp_t predict(input logic [15:0] l,
                                    input logic [11:0] ax,
                                    input logic [11:0] ay,
                                    input int          mt,
                                    input logic [7:0]  c);
      exp_t e;
      logic [11:0] cx, cy;
      bit done;
      done = 1'b0;
      e.c = (c == 8'hFF) ? c : c + 8'd1;
      e.x = '0;
      e.y = '0;
      e.n = 0;
      for (int t = 0; t < mt && !done; t++) begin
         cx = {1'b0, l[10:0]};
         cy = {2'b0, l[15:11], l[4:0]};
         if (in_field(cx, cy) && !(cx == ax && cy == ay)) begin
            e.x = cx;
            e.y = cy;
            e.n = 3 + 2 * t;
            done = 1'b1;
         end else begin
            l = nx(nx(l));
         end
      end
      if (!done) begin
         e.n = 3 + 2 * (mt - 1);
         if (ax == 50 && ay == 50) begin
            e.x = 1230;
            e.y = 670;
         end else begin
            e.x = 50;
            e.y = 50;
         end
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0 <= 16'hACE1;
         m1 <= 16'hFFFF;
      end else begin
         m0 <= nx(m0);
         m1 <= nx(m1);
      end
   end

   task automatic model_reset();
      ax0 = 400; ay0 = 200; c0 = 0;
      ax1 = 400; ay1 = 200; c1 = 0;
   endtask

   task automatic place0();
      exp_t e;
      int k;
      @(negedge clk);
      if0.apple_refresh = 1'b1;
      @(posedge clk);
      #1;
      if0.apple_refresh = 1'b0;
      sbq.push_back(predict(m0, ax0, ay0, 64, c0));
      k = 0;
      while (if0.busy && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      total++;
      if (sbq.size() == 0) begin
         $display("FAIL place_sb: queue empty, required 1 entry");
         return;
      end
      passed++;
      e = sbq.pop_front();
      total++;
      if (k !== e.n)
         $display("FAIL place_lat: got %0d clks, required %0d", k, e.n);
      else passed++;
      total++;
      if ({if0.apple_x, if0.apple_y} !== {e.x, e.y})
         $display("FAIL place_xy: got (%0d,%0d), required (%0d,%0d)",
                  if0.apple_x, if0.apple_y, e.x, e.y);
      else passed++;
      total++;
      if (!in_field(if0.apple_x, if0.apple_y))
         $display("FAIL place_range: got (%0d,%0d), required inside field",
                  if0.apple_x, if0.apple_y);
      else passed++;
      total++;
      if (if0.apple_count !== e.c)
         $display("FAIL place_cnt: got %0d, required %0d",
                  if0.apple_count, e.c);
      else passed++;
      ax0 = e.x; ay0 = e.y; c0 = e.c;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if0.apple_refresh = 0; if0.game_status = 0;
      if0.x_pos = 0; if0.y_pos = 0;
      if1.apple_refresh = 0; if1.game_status = 0;
      if1.x_pos = 0; if1.y_pos = 0;
      model_reset();
      #23;
      total++;
      if ({if0.apple_x, if0.apple_y, if0.busy, if0.apple_count} !==
          {12'd400, 12'd200, 1'b0, 8'd0})
         $display("FAIL reset0: got (%0d,%0d) busy=%0b cnt=%0d, required (400,200) 0 0",
                  if0.apple_x, if0.apple_y, if0.busy, if0.apple_count);
      else passed++;
      total++;
      if ({if1.apple_x, if1.apple_y, if1.busy, if1.apple_count} !==
          {12'd400, 12'd200, 1'b0, 8'd0})
         $display("FAIL reset1: got (%0d,%0d) busy=%0b cnt=%0d, required (400,200) 0 0",
                  if1.apple_x, if1.apple_y, if1.busy, if1.apple_count);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_pixel();
      logic [11:0] px[4] = '{12'd390, 12'd389, 12'd410, 12'd400};
      logic [11:0] py[4] = '{12'd210, 12'd200, 12'd190, 12'd211};
      logic        pe[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         if0.x_pos = px[i];
         if0.y_pos = py[i];
         #1;
         total++;
         if (if0.apple !== pe[i])
            $display("FAIL pixel(%0d,%0d): got %0b, required %0b",
                     px[i], py[i], if0.apple, pe[i]);
         else passed++;
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < 3; i++) place0();
      if0.x_pos = ax0 + 12'd10;
      if0.y_pos = ay0 - 12'd10;
      #1;
      total++;
      if (if0.apple !== 1'b1)
         $display("FAIL pixel_corner: got %0b, required 1", if0.apple);
      else passed++;
   endtask

   task automatic test_hold();
      exp_t e;
      int k;
      @(negedge clk);
      if0.apple_refresh = 1'b1;
      @(posedge clk);
      #1;
      sbq.push_back(predict(m0, ax0, ay0, 64, c0));
      repeat (20) @(posedge clk);
      #1;
      if0.apple_refresh = 1'b0;
      k = 0;
      while (if0.busy && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (10) @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (if0.apple_count !== e.c)
         $display("FAIL hold_cnt: got %0d, required %0d", if0.apple_count, e.c);
      else passed++;
      total++;
      if ({if0.apple_x, if0.apple_y} !== {e.x, e.y})
         $display("FAIL hold_xy: got (%0d,%0d), required (%0d,%0d)",
                  if0.apple_x, if0.apple_y, e.x, e.y);
      else passed++;
      ax0 = e.x; ay0 = e.y; c0 = e.c;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int k;
      @(negedge clk);
      if0.apple_refresh = 1'b1;
      @(posedge clk);
      #1;
      if0.apple_refresh = 1'b0;
      sbq.push_back(predict(m0, ax0, ay0, 64, c0));
      @(posedge clk);
      @(negedge clk);
      if0.apple_refresh = 1'b1;
      @(posedge clk);
      #1;
      if0.apple_refresh = 1'b0;
      k = 2;
      while (if0.busy && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      e = sbq.pop_front();
      total++;
      if (k !== e.n)
         $display("FAIL b2b_lat: got %0d clks, required %0d", k, e.n);
      else passed++;
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (if0.busy !== 1'b0 || if0.apple_count !== e.c)
         $display("FAIL b2b_drop: busy=%0b cnt=%0d, required busy=0 cnt=%0d",
                  if0.busy, if0.apple_count, e.c);
      else passed++;
      total++;
      if ({if0.apple_x, if0.apple_y} !== {e.x, e.y})
         $display("FAIL b2b_xy: got (%0d,%0d), required (%0d,%0d)",
                  if0.apple_x, if0.apple_y, e.x, e.y);
      else passed++;
      ax0 = e.x; ay0 = e.y; c0 = e.c;
   endtask

   task automatic test_restart();
      @(negedge clk);
      if0.apple_refresh = 1'b1;
      @(posedge clk);
      #1;
      if0.apple_refresh = 1'b0;
      @(negedge clk);
      total++;
      if (if0.busy !== 1'b1)
         $display("FAIL rst_busy: got %0b, required 1", if0.busy);
      else passed++;
      if0.game_status = 2'b10;
      @(posedge clk);
      #1;
      if0.game_status = 2'b00;
      total++;
      if ({if0.busy, if0.apple_x, if0.apple_y, if0.apple_count} !==
          {1'b0, 12'd400, 12'd200, 8'd0})
         $display("FAIL restart: busy=%0b (%0d,%0d) cnt=%0d, required 0 (400,200) 0",
                  if0.busy, if0.apple_x, if0.apple_y, if0.apple_count);
      else passed++;
      repeat (150) @(posedge clk);
      #1;
      total++;
      if ({if0.busy, if0.apple_x, if0.apple_y, if0.apple_count} !==
          {1'b0, 12'd400, 12'd200, 8'd0})
         $display("FAIL restart_hold: busy=%0b (%0d,%0d) cnt=%0d, required 0 (400,200) 0",
                  if0.busy, if0.apple_x, if0.apple_y, if0.apple_count);
      else passed++;
      ax0 = 400; ay0 = 200; c0 = 0;
   endtask

   task automatic test_fallback();
      logic [11:0] ex[2] = '{12'd50, 12'd1230};
      logic [11:0] ey[2] = '{12'd50, 12'd670};
      logic [15:0] l;
      int k;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            l = nx(m1);
            if (!in_field({1'b0, l[10:0]}, {2'b0, l[15:11], l[4:0]})) break;
         end
         if1.apple_refresh = 1'b1;
         @(posedge clk);
         #1;
         if1.apple_refresh = 1'b0;
         k = 0;
         while (if1.busy && k < 50) begin
            @(posedge clk);
            #1;
            k++;
         end
         total++;
         if (k !== 3)
            $display("FAIL fb_lat%0d: got %0d clks, required 3", r, k);
         else passed++;
         total++;
         if ({if1.apple_x, if1.apple_y} !== {ex[r], ey[r]})
            $display("FAIL fb_xy%0d: got (%0d,%0d), required (%0d,%0d)",
                     r, if1.apple_x, if1.apple_y, ex[r], ey[r]);
         else passed++;
         total++;
         if (if1.apple_count !== 8'(r + 1))
            $display("FAIL fb_cnt%0d: got %0d, required %0d",
                     r, if1.apple_count, r + 1);
         else passed++;
      end
   endtask

   task automatic test_saturate();
      while (c0 != 8'hFF) place0();
      place0();
      place0();
      total++;
      if (if0.apple_count !== 8'hFF)
         $display("FAIL sat_cnt: got %0d, required 255", if0.apple_count);
      else passed++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      if0.apple_refresh = 1'b1;
      @(posedge clk);
      #1;
      if0.apple_refresh = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({if0.apple_x, if0.apple_y, if0.busy, if0.apple_count} !==
          {12'd400, 12'd200, 1'b0, 8'd0})
         $display("FAIL reset_mid: got (%0d,%0d) busy=%0b cnt=%0d, required (400,200) 0 0",
                  if0.apple_x, if0.apple_y, if0.busy, if0.apple_count);
      else passed++;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      place0();
   endtask

   initial begin
      test_reset();
      test_pixel();
      test_single();
      test_hold();
      test_back_to_back();
      test_restart();
      test_fallback();
      test_saturate();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
